// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the instruction loader.
//   - default parameter constants
//   - loader FSM state encoding
//   - start-of-load length header format (16-bit word count, low byte first)
package loader_pkg;

   localparam int unsigned DEF_ADDR_WIDTH     = 16;
   localparam int unsigned DEF_MAX_WORDS      = 1024;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 50_000_000;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      DONE,
      ERR
   } state_t;

   // Length header as it arrives on the link: lo byte first, then hi byte.
   typedef struct packed {
      logic [7:0] hi;
      logic [7:0] lo;
   } len_hdr_t;

   function automatic logic [15:0] hdr_count(input len_hdr_t h);
      return {h.hi, h.lo};
   endfunction

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs four bytes little-endian into a 32-bit word.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   clear          synchronous clear of any partial word
//   valid, byte_in incoming byte strobe and data
//   word           assembled word (valid while word_ready is high)
//   word_ready     high in the cycle the 4th byte of a word is presented
module word_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_ready
);

   logic [1:0] idx;
   logic [7:0] b0, b1, b2;

   // The 4th byte is combined directly so the word is available in the
   // same cycle it arrives; no storage is needed for it.
   assign word_ready = valid && (idx == 2'd3);
   assign word       = {byte_in, b2, b1, b0};

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         idx <= '0;
         b0  <= '0;
         b1  <= '0;
         b2  <= '0;
      end else if (valid) begin
         case (idx)
            2'd0:    b0 <= byte_in;
            2'd1:    b1 <= byte_in;
            2'd2:    b2 <= byte_in;
            default: ;
         endcase
         idx <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: receives a program over a byte link and writes it into
// instruction memory while holding the processor in reset.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   start                     one-cycle pulse beginning a load
//   rx_valid, rx_byte         incoming byte strobe and data
//   imem_we/addr/wdata        instruction-memory write port
//   cpu_hold                  processor reset (1 = held)
//   busy, done, err           loader status
module inst_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned MAX_WORDS      = DEF_MAX_WORDS,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   // Counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t        state, state_next;
   logic [7:0]    len_lo;
   logic [15:0]   len_words;
   logic [15:0]   k;
   logic [TW-1:0] tcount;
   len_hdr_t      hdr;
   logic [15:0]   hdr_n;
   logic          timed_out;
   logic          write_word;
   logic          restart;
   logic          asm_clear;
   logic          asm_valid;
   logic          word_ready;
   logic [31:0]   word;

   assign hdr       = '{hi: rx_byte, lo: len_lo};
   assign hdr_n     = hdr_count(hdr);
   assign timed_out = !rx_valid && (tcount == TW'(TIMEOUT_CYCLES - 1));
   // Holding the assembler clear outside DATA discards any partial word
   // on timeout/restart and guarantees byte index 0 on entry to DATA.
   assign asm_clear = (state != DATA);
   assign asm_valid = rx_valid && (state == DATA);

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (asm_clear),
      .valid      (asm_valid),
      .byte_in    (rx_byte),
      .word       (word),
      .word_ready (word_ready)
   );

   always_comb begin
      state_next = state;
      write_word = 1'b0;
      restart    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      cpu_hold   = 1'b1;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LEN_LO;
               restart    = 1'b1;
            end
         end
         LEN_LO: begin
            busy = 1'b1;
            if (rx_valid)       state_next = LEN_HI;
            else if (timed_out) state_next = ERR;
         end
         LEN_HI: begin
            busy = 1'b1;
            if (rx_valid) begin
               if (hdr_n == 16'd0)               state_next = DONE;
               else if (32'(hdr_n) > MAX_WORDS)  state_next = ERR;
               else                              state_next = DATA;
            end else if (timed_out) begin
               state_next = ERR;
            end
         end
         DATA: begin
            busy = 1'b1;
            if (word_ready) begin
               write_word = 1'b1;
               if (k + 16'd1 == len_words) state_next = DONE;
            end else if (timed_out) begin
               state_next = ERR;
            end
         end
         DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) begin
               state_next = LEN_LO;
               restart    = 1'b1;
            end
         end
         ERR: begin
            err = 1'b1;
            if (start) begin
               state_next = LEN_LO;
               restart    = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         len_lo     <= '0;
         len_words  <= '0;
         k          <= '0;
         tcount     <= '0;
      end else begin
         state   <= state_next;
         imem_we <= write_word;
         if (write_word) begin
            imem_addr  <= ADDR_WIDTH'({k, 2'b00});
            imem_wdata <= word;
            k          <= k + 16'd1;
         end
         if (restart) k <= '0;
         if (state == LEN_LO && rx_valid) len_lo    <= rx_byte;
         if (state == LEN_HI && rx_valid) len_words <= hdr_n;
         if (restart || (busy && rx_valid)) tcount <= '0;
         else if (busy)                     tcount <= tcount + TW'(1);
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        imem_we;
   logic [15:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;

   int nchecks = 0;
   int nfail   = 0;

   logic [15:0] wa[$];
   logic [31:0] wd[$];

   inst_loader #(
      .ADDR_WIDTH     (16),
      .MAX_WORDS      (1024),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every write the memory would see at a clock edge.
   always @(posedge clk) begin
      if (imem_we === 1'b1) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
      end
   end

   task automatic check1(input string tag, input logic obs, input logic exp);
      nchecks++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check1({tag, "_we"}, imem_we, 1'b0);
      check32({tag, "_addr"}, 32'(imem_addr), 32'h0);
      check32({tag, "_wdata"}, imem_wdata, 32'h0);
      check1({tag, "_busy"}, busy, 1'b0);
      check1({tag, "_done"}, done, 1'b0);
      check1({tag, "_err"}, err, 1'b0);
      check1({tag, "_hold"}, cpu_hold, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;

      // Reset state
      idle(3);
      check_reset_values("rst0");
      rst = 1'b1;
      idle(2);
      check1("idle_ignores_rx_busy", busy, 1'b0);

      // Two-word program with gaps, start pulse during DATA ignored
      clear_log();
      pulse_start();
      check1("t1_busy", busy, 1'b1);
      check1("t1_hold", cpu_hold, 1'b1);
      send_byte(8'h02); send_byte(8'h00);
      idle(1);
      send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
      check1("t1_w0_we", imem_we, 1'b1);
      check32("t1_w0_addr", 32'(imem_addr), 32'h0);
      check32("t1_w0_data", imem_wdata, 32'h00A00513);
      check1("t1_w0_done", done, 1'b0);
      pulse_start();
      check1("t1_start_ignored_busy", busy, 1'b1);
      check1("t1_we_one_cycle", imem_we, 1'b0);
      send_byte(8'h93); send_byte(8'h05); send_byte(8'hB0); send_byte(8'h00);
      check1("t1_w1_we", imem_we, 1'b1);
      check32("t1_w1_addr", 32'(imem_addr), 32'h4);
      check32("t1_w1_data", imem_wdata, 32'h00B00593);
      check1("t1_done", done, 1'b1);
      check1("t1_hold_released", cpu_hold, 1'b0);
      check1("t1_busy_low", busy, 1'b0);
      idle(2);
      check32("t1_nwrites", 32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
         check32("t1_log_a0", 32'(wa[0]), 32'h0);
         check32("t1_log_d0", wd[0], 32'h00A00513);
         check32("t1_log_a1", 32'(wa[1]), 32'h4);
         check32("t1_log_d1", wd[1], 32'h00B00593);
      end

      // Zero-length program
      clear_log();
      pulse_start();
      check1("t2_done_cleared", done, 1'b0);
      check1("t2_busy", busy, 1'b1);
      send_byte(8'h00);
      check1("t2_not_done_yet", done, 1'b0);
      send_byte(8'h00);
      check1("t2_done", done, 1'b1);
      check1("t2_hold", cpu_hold, 1'b0);
      idle(3);
      check32("t2_nwrites", 32'(wa.size()), 32'd0);

      // Over-length program: 0x0401 words
      clear_log();
      pulse_start();
      send_byte(8'h01); send_byte(8'h04);
      check1("t3_err", err, 1'b1);
      check1("t3_hold", cpu_hold, 1'b1);
      check1("t3_busy", busy, 1'b0);
      check1("t3_done", done, 1'b0);
      idle(3);
      check32("t3_nwrites", 32'(wa.size()), 32'd0);

      // Exactly MAX_WORDS is accepted; abort with reset
      pulse_start();
      check1("t4_err_cleared", err, 1'b0);
      send_byte(8'h00); send_byte(8'h04);
      check1("t4_max_busy", busy, 1'b1);
      check1("t4_max_no_err", err, 1'b0);
      rst = 1'b0;
      idle(1);
      check_reset_values("t4_rst");
      rst = 1'b1;

      // Timeout mid-word, then successful reload
      clear_log();
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB);
      idle(99);
      check1("t5_no_err_at_99", err, 1'b0);
      check1("t5_busy_at_99", busy, 1'b1);
      idle(1);
      check1("t5_err_at_100", err, 1'b1);
      check1("t5_hold", cpu_hold, 1'b1);
      check32("t5_nwrites", 32'(wa.size()), 32'd0);
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      check1("t5_reload_we", imem_we, 1'b1);
      check32("t5_reload_addr", 32'(imem_addr), 32'h0);
      check32("t5_reload_data", imem_wdata, 32'hDEADBEEF);
      check1("t5_reload_done", done, 1'b1);

      // Reset after two bytes of word 1
      idle(1);
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      check32("t6_w0_data", imem_wdata, 32'h44332211);
      send_byte(8'h55); send_byte(8'h66);
      clear_log();
      rst = 1'b0;
      idle(1);
      check_reset_values("t6_rst");
      rst = 1'b1;
      idle(1);
      check32("t6_nwrites_during_rst", 32'(wa.size()), 32'd0);
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      check1("t6_we", imem_we, 1'b1);
      check32("t6_addr", 32'(imem_addr), 32'h0);
      check32("t6_data", imem_wdata, 32'h12345678);
      check1("t6_done", done, 1'b1);

      // Ten bytes on ten consecutive cycles
      idle(1);
      clear_log();
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      check1("t7_we", imem_we, 1'b1);
      check32("t7_addr", 32'(imem_addr), 32'h4);
      check32("t7_data", imem_wdata, 32'h08070605);
      check1("t7_done", done, 1'b1);
      idle(2);
      check32("t7_nwrites", 32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
         check32("t7_log_a0", 32'(wa[0]), 32'h0);
         check32("t7_log_d0", wd[0], 32'h04030201);
         check32("t7_log_a1", 32'(wa[1]), 32'h4);
         check32("t7_log_d1", wd[1], 32'h08070605);
      end

      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end

endmodule
